// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
// Build option: FIFO_WATERMARK_EN adds the peak-occupancy output.
package sync_fifo_pkg;

  localparam int AFULL_MIN  = 1;
  localparam int AEMPTY_MIN = 0;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit thresh_ok(
    input int depth,
    input int af,
    input int ae
  );
    return (af >= AFULL_MIN) && (af <= depth) &&
           (ae >= AEMPTY_MIN) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle of the synchronous FIFO.
// master drives requests, slave is the FIFO itself.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl_mem.sv
// Flop-array storage with one write port and a registered,
// read-enabled read port. Storage is not reset; rdata is.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, flags, error pulses.
// Build option: FIFO_WATERMARK_EN adds max_level (peak count since reset).
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_if.slave         bus
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [ADDR_WIDTH:0] max_level
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = count_width(DEPTH);
  localparam bit THRESH_OK =
    thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance looks only at registered flags, never same-cycle requests.
  always_comb begin
    wr_acc     = bus.wr_en & ~full_q;
    rd_acc     = bus.rd_en & ~empty_q;
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(rd_acc);
    count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    afull_d    = (count_d >= CW'(AFULL_THRESH));
    aempty_d   = (count_d <= CW'(AEMPTY_THRESH));
    ovf_d      = bus.wr_en & full_q;
    unf_d      = bus.rd_en & empty_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (THRESH_OK);
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr_q),
    .rdata (bus.rd_data)
  );

`ifdef FIFO_WATERMARK_EN
  logic [CW-1:0] max_level_q, max_level_d;

  always_comb begin
    max_level_d = max_level_q;
    if (count_d > max_level_q) max_level_d = count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) max_level_q <= '0;
    else     max_level_q <= max_level_d;
  end

  assign max_level = max_level_q;
`endif

  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sync_fifo_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef FIFO_WATERMARK_EN
  logic [AW:0] max_level;
`endif

  sync_fifo_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_WATERMARK_EN
    ,
    .max_level (max_level)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid, m_ovf, m_unf;
  int            m_max;
  bit            m_full, m_empty;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_max      = 0;
    end else begin
      m_full     = (mq.size() == DEPTH);
      m_empty    = (mq.size() == 0);
      m_ovf      = bus.wr_en && m_full;
      m_unf      = bus.rd_en && m_empty;
      m_rd_valid = bus.rd_en && !m_empty;
      if (m_rd_valid) m_rd_data = mq.pop_front();
      if (bus.wr_en && !m_full) mq.push_back(bus.wr_data);
      if (mq.size() > m_max) m_max = mq.size();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rd_valid", bus.rd_valid, m_rd_valid);
      chk("m_rd_data", bus.rd_data, m_rd_data);
      chk("m_count", bus.count, mq.size());
      chk("m_full", bus.full, mq.size() == DEPTH);
      chk("m_empty", bus.empty, mq.size() == 0);
      chk("m_afull", bus.almost_full, mq.size() >= AF);
      chk("m_aempty", bus.almost_empty, mq.size() <= AE);
      chk("m_overflow", bus.overflow, m_ovf);
      chk("m_underflow", bus.underflow, m_unf);
`ifdef FIFO_WATERMARK_EN
      chk("m_max_level", max_level, m_max);
`endif
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic rs);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    rst         = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bias_w, bias_r;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst         = 1'b1;

    // 1: reset, fill, overflow
    step(0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_aempty", bus.almost_empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, DW'(i + 1), 0, 0);
      if (i == 10) chk("af_at_11", bus.almost_full, 0);
      if (i == 11) chk("af_at_12", bus.almost_full, 1);
      if (i == 14) chk("full_at_15", bus.full, 0);
    end
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 16);
    step(1, 16'hDEAD, 0, 0);
    chk("ovf_pulse", bus.overflow, 1);
    chk("ovf_count", bus.count, 16);
    step(0, 0, 0, 0);
    chk("ovf_clear", bus.overflow, 0);

    // 2: drain in order, underflow
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      chk("drain_valid", bus.rd_valid, 1);
      chk("drain_data", bus.rd_data, i + 1);
      if (i == 12) chk("ae_at_3", bus.almost_empty, 0);
      if (i == 13) chk("ae_at_2", bus.almost_empty, 1);
    end
    chk("drain_empty", bus.empty, 1);
    step(0, 0, 1, 0);
    chk("unf_pulse", bus.underflow, 1);
    chk("unf_hold", bus.rd_data, 16'h0010);
    chk("unf_valid", bus.rd_valid, 0);
    step(0, 0, 0, 0);
    chk("unf_clear", bus.underflow, 0);

    // 3: pointer wrap
    for (int i = 0; i < 10; i++) step(1, DW'(16'h9000 + i), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, DW'(16'hA000 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0);
      chk("wrap_data", bus.rd_data, 16'hA000 + i);
    end
    chk("wrap_count", bus.count, 0);

    // 4: simultaneous read/write at 5, full, empty
    for (int i = 0; i < 5; i++) step(1, DW'(16'hB000 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, DW'(16'hC000 + i), 1, 0);
      chk("rw_count", bus.count, 5);
      chk("rw_data", bus.rd_data,
          (i < 5) ? 16'hB000 + i : 16'hC000 + i - 5);
    end
    for (int i = 0; i < 11; i++) step(1, DW'(16'hD000 + i), 0, 0);
    chk("rw_full", bus.full, 1);
    step(1, 16'h1234, 1, 0);
    chk("rwfull_count", bus.count, 15);
    chk("rwfull_ovf", bus.overflow, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0);
    chk("rw_empty", bus.empty, 1);
    step(1, 16'hE000, 1, 0);
    chk("rwempty_count", bus.count, 1);
    chk("rwempty_unf", bus.underflow, 1);
    chk("rwempty_valid", bus.rd_valid, 0);

    // 5: reset mid-stream at count 7
    for (int i = 0; i < 6; i++) step(1, DW'(16'hF000 + i), 0, 0);
    chk("pre_rst_count", bus.count, 7);
    step(1, 16'hFFFF, 1, 1);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_valid", bus.rd_valid, 0);
    chk("mid_rst_data", bus.rd_data, 0);
    step(1, 16'h5A5A, 0, 0);
    step(0, 0, 1, 0);
    chk("post_rst_data", bus.rd_data, 16'h5A5A);
    chk("post_rst_valid", bus.rd_valid, 1);

`ifdef FIFO_WATERMARK_EN
    // 6: watermark
    step(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, DW'(i), 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, DW'(i), 0, 0);
    chk("wm_peak", max_level, 9);
    step(0, 0, 0, 1);
    chk("wm_rst", max_level, 0);
`endif

    // Random traffic with shifting bias and rare resets
    bias_w = 50;
    bias_r = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(2))
          0: begin bias_w = 80; bias_r = 30; end
          1: begin bias_w = 30; bias_r = 80; end
          default: begin bias_w = 60; bias_r = 60; end
        endcase
      end
      step(($urandom_range(99) < bias_w),
           DW'($urandom),
           ($urandom_range(99) < bias_r),
           ($urandom_range(149) == 0));
    end
    step(0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
